// File: rtl/mux_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | mux_arb_pkg : shared constants and helpers for the mux round-robin arbiter |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int DEF_MAX_HOLD = 8;

  function automatic logic [N_REQ-1:0] idx2oh(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_next4.sv
// +--------------------------------------------------------------------------+
// | rr_next4 : combinational 4-way round-robin pick starting after 'last'     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_next4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] pos;

  // A set mask bit removes that requester from the pick.
  assign cand  = req & ~mask;
  assign found = |cand;

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    idx = '0;
    pos = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = last + IDX_W'(k);
      if (cand[pos]) idx = pos;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | mux_rr_arbiter : round-robin owner of the 4:1 mux selects, hold-limited   |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic             s0,
  output logic             s1,
  output logic             busy
);

  localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [IDX_W-1:0] sel_q,   sel_d;
  logic             busy_q,  busy_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0] hold_q,  hold_d;

  logic [N_REQ-1:0] w_mask;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // While granting, last_q is the owner; exclude it from any new pick.
  assign w_mask = (state_q == ST_GRANT) ? idx2oh(last_q) : '0;

  rr_next4 u_pick (
    .req   (req),
    .mask  (w_mask),
    .last  (last_q),
    .found (w_found),
    .idx   (w_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    last_d  = last_q;
    hold_d  = hold_q;
    if ((state_q == ST_IDLE) || !req[last_q] || (hold_q == C_HOLD_LAST)) begin
      if (en && w_found) begin
        state_d = ST_GRANT;
        gnt_d   = idx2oh(w_idx);
        sel_d   = w_idx;
        busy_d  = 1'b1;
        last_d  = w_idx;
        hold_d  = '0;
      end else if (state_q == ST_GRANT && !req[last_q]) begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end else if (state_q == ST_GRANT && en) begin
        // Expiry with nobody waiting: owner keeps the mux, window restarts.
        hold_d = '0;
      end
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= IDX_W'(N_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt  = gnt_q;
  assign s0   = sel_q[1];
  assign s1   = sel_q[0];
  assign busy = busy_q;

endmodule

`default_nettype wire
